// File: rtl/seq_divider_p_bit.sv
// rtl/seq_divider_p_bit.sv - sequential P-bit restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands (magnitude core, sign fix-up in FIN).
module seq_divider_p_bit #(
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [P-1:0] A,
  input  logic [P-1:0] B,
  output logic [P-1:0] Quotient,
  output logic [P-1:0] Remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int CW = $clog2(P + 1);
  localparam logic [CW-1:0] CNT_P   = CW'(P);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [P-1:0]  rem_q, rem_d;
  logic [P-1:0]  dvd_q, dvd_d;
  logic [P-1:0]  quo_q, quo_d;
  logic [P-1:0]  dvs_q, dvs_d;
  logic [P-1:0]  a_q, a_d;
  logic          dbz_q, dbz_d;
  logic [P-1:0]  quo_o_q, quo_o_d;
  logic [P-1:0]  rem_o_q, rem_o_d;
  logic          done_q, done_d;
  logic          dbz_o_q, dbz_o_d;

  logic [P-1:0]  a_mag, b_mag;
  logic [P-1:0]  fin_quo, fin_rem;
  logic [P:0]    shifted, diff;
  logic          accept;

  assign accept = (state_q == S_IDLE) && start;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic negq_q, negq_d, negr_q, negr_d;

  assign a_mag   = A[P-1] ? -A : A;
  assign b_mag   = B[P-1] ? -B : B;
  assign negq_d  = accept ? (A[P-1] ^ B[P-1]) : negq_q;
  assign negr_d  = accept ? A[P-1] : negr_q;
  // Most-negative / -1 yields magnitude 2^(P-1), whose negation wraps back to itself.
  assign fin_quo = negq_q ? -quo_q : quo_q;
  assign fin_rem = negr_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign a_mag   = A;
  assign b_mag   = B;
  assign fin_quo = quo_q;
  assign fin_rem = rem_q;
`endif

  // Trial subtraction on the (P+1)-bit shifted partial remainder; the top bit is the borrow.
  assign shifted = {rem_q, dvd_q[P-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    dbz_d   = dbz_q;
    quo_o_d = quo_o_q;
    rem_o_d = rem_o_q;
    dbz_o_d = dbz_o_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d = a_mag;
          dvs_d = b_mag;
          a_d   = A;
          rem_d = '0;
          quo_d = '0;
          cnt_d = CNT_P;
          if (B == '0) begin
            dbz_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            dbz_d   = 1'b0;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        dvd_d = {dvd_q[P-2:0], 1'b0};
        if (!diff[P]) begin
          rem_d = diff[P-1:0];
          quo_d = {quo_q[P-2:0], 1'b1};
        end else begin
          rem_d = shifted[P-1:0];
          quo_d = {quo_q[P-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        dbz_o_d = dbz_q;
        if (dbz_q) begin
          quo_o_d = '1;
          rem_o_d = a_q;
        end else begin
          quo_o_d = fin_quo;
          rem_o_d = fin_rem;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      dbz_q   <= 1'b0;
      quo_o_q <= '0;
      rem_o_q <= '0;
      done_q  <= 1'b0;
      dbz_o_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      dbz_q   <= dbz_d;
      quo_o_q <= quo_o_d;
      rem_o_q <= rem_o_d;
      done_q  <= done_d;
      dbz_o_q <= dbz_o_d;
    end
  end

  assign Quotient    = quo_o_q;
  assign Remainder   = rem_o_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_o_q;

endmodule

// File: tb/tb_seq_divider_p_bit.sv
// tb/tb_seq_divider_p_bit.sv - self-checking bench for seq_divider_p_bit (honours SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider_p_bit;

  localparam int P = 4;

  typedef struct {
    logic [P-1:0] a;
    logic [P-1:0] b;
    logic [P-1:0] q;
    logic [P-1:0] r;
    logic         dbz;
  } vec_t;

  typedef struct {
    logic [P-1:0] q;
    logic [P-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [P-1:0] A;
  logic [P-1:0] B;
  logic [P-1:0] Quotient;
  logic [P-1:0] Remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int   n_vec;
  int   n_bad;
  int   done_cnt;
  exp_t sb[$];
  vec_t tbl[8];

  seq_divider_p_bit #(.P(P)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .Quotient(Quotient),
    .Remainder(Remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [P-1:0] a, input logic [P-1:0] b);
    exp_t e;
    int   sa, sb_i;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
`else
      sa   = int'(a);
      sb_i = int'(b);
`endif
      e.q = P'(sa / sb_i);
      e.r = P'(sa % sb_i);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(Quotient), 32'(e.q));
        check("remainder", 32'(Remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  // Drive start at #1 after an edge; returns #1 after the accepting edge.
  task automatic launch(input logic [P-1:0] a, input logic [P-1:0] b, input exp_t e);
    start = 1'b1;
    A = a;
    B = b;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int k;
    int bc;
    k  = 0;
    bc = busy ? 1 : 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if (busy) bc++;
    end
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
  endtask

  initial begin
    exp_t e;
    int   base;
    logic [P-1:0] ra, rb;

`ifdef SEQ_DIVIDER_SIGNED_EN
    tbl[0] = '{4'd9,  4'd2,  4'd13, 4'd15, 1'b0};
    tbl[1] = '{4'd8,  4'd15, 4'd8,  4'd0,  1'b0};
    tbl[2] = '{4'd7,  4'd14, 4'd13, 4'd1,  1'b0};
    tbl[3] = '{4'd9,  4'd14, 4'd3,  4'd15, 1'b0};
    tbl[4] = '{4'd5,  4'd0,  4'd15, 4'd5,  1'b1};
    tbl[5] = '{4'd6,  4'd3,  4'd2,  4'd0,  1'b0};
    tbl[6] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    tbl[7] = '{4'd12, 4'd5,  4'd0,  4'd12, 1'b0};
`else
    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0};
    tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    tbl[2] = '{4'd2,  4'd3,  4'd0,  4'd2,  1'b0};
    tbl[3] = '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1};
    tbl[4] = '{4'd9,  4'd4,  4'd2,  4'd1,  1'b0};
    tbl[5] = '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0};
    tbl[6] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    tbl[7] = '{4'd14, 4'd4,  4'd3,  4'd2,  1'b0};
`endif

    n_vec = 0;
    n_bad = 0;
    done_cnt = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_quotient", 32'(Quotient), 32'd0);
    check("rst_remainder", 32'(Remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);

    for (int i = 0; i < 8; i++) begin
      e.q = tbl[i].q;
      e.r = tbl[i].r;
      e.dbz = tbl[i].dbz;
      launch(tbl[i].a, tbl[i].b, e);
      wait_done((tbl[i].b == '0) ? 1 : P + 1, "table");
      @(posedge clk);
      #1;
    end

    // start pulsed mid-division must be ignored
    base = done_cnt;
    launch(4'd12, 4'd5, model(4'd12, 4'd5));
    @(posedge clk);
    #1;
    start = 1'b1;
    A = 4'd1;
    B = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ignored_start_done_count", 32'(done_cnt - base), 32'd1);

    // reset during the third DIV cycle aborts with no done
    start = 1'b1;
    A = 4'd11;
    B = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    base = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_quotient", 32'(Quotient), 32'd0);
    check("abort_remainder", 32'(Remainder), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - base), 32'd0);

    // back-to-back: second start issued in the done cycle of the first
    launch(4'd6, 4'd3, model(4'd6, 4'd3));
    wait_done(P + 1, "b2b_first");
    launch(4'd8, 4'd8, model(4'd8, 4'd8));
    wait_done(P + 1, "b2b_second");
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      ra = P'($urandom);
      rb = P'($urandom);
      launch(ra, rb, model(ra, rb));
      wait_done((rb == '0) ? 1 : P + 1, "random");
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
